pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch-sequencing stage of the single-issue core.
- Drives prog_ctr to instruction memory and to the return-address/branch-target LUT stage as its `addr` input.
- Consumes that LUT's registered target one cycle after a redirect request.
- Sequences start, halt, stall and redirect bubbles, and keeps a run-cycle counter for the test harness.

Parameters:
D, 12, program-counter width in bits.
START_PC, 0, PC loaded on start.
CNT_W, 16, width of run-cycle counter.

Ports:
clk  input  1  core clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse; begins execution from START_PC (honoured in IDLE and HALT only).
halt_req  input  1  decode saw a halt instruction; stop fetch.
stall  input  1  downstream hazard; hold PC.
redirect  input  1  decode saw a taken branch/jump/call/ret this cycle (same cycle the LUT stage sees call/ret).
target  input  D  registered next-PC from the LUT stage; valid exactly one cycle after redirect.
prog_ctr  output  D  current fetch address.
fetch_valid  output  1  instruction at prog_ctr is valid for decode.
done  output  1  execution finished; sticky until next start.
run_cycles  output  CNT_W  cycles spent in RUN or TGT_WAIT since last start, saturating.

Behaviour:
Reset (rst_n low, asynchronous, any state, including mid-redirect):
- state = IDLE, prog_ctr = 0, fetch_valid = 0, done = 0, run_cycles = 0.
- Effective immediately; the first state update is on the first rising edge with rst_n high.

States and transitions:
- IDLE:
  - start = 1 -> RUN; prog_ctr <= START_PC; fetch_valid <= 1; run_cycles <= 0.
  - All other inputs are ignored.
- RUN: one action per edge, priority halt_req > redirect > stall > increment.
  - halt_req: -> HALT; done <= 1; fetch_valid <= 0; prog_ctr holds.
  - redirect: -> TGT_WAIT; fetch_valid <= 0 (one bubble); prog_ctr holds. The LUT therefore still sees the call-site address.
  - stall: prog_ctr holds; fetch_valid stays 1.
  - otherwise: prog_ctr <= prog_ctr + 1.
    - If prog_ctr == 2^D-1, there is no wrap: -> HALT; done <= 1; fetch_valid <= 0; prog_ctr holds at 2^D-1.
- TGT_WAIT: lasts exactly one cycle; target is sampled at the closing edge.
  - halt_req = 1: -> HALT; done <= 1; target is discarded.
  - otherwise: prog_ctr <= target; fetch_valid <= 1; -> RUN.
  - stall and redirect are ignored here. Decode cannot issue during the bubble; the stall applies from the next RUN cycle.
- HALT:
  - prog_ctr and done hold; fetch_valid = 0.
  - start = 1 -> RUN exactly as from IDLE; done <= 0; run_cycles <= 0.

run_cycles:
- Increments by 1 on every edge ending a cycle in RUN or TGT_WAIT.
- Saturates at 2^CNT_W-1.
- Holds in IDLE and HALT.

Other rules:
- Simultaneous start with any other input in IDLE/HALT: only start acts.
- All outputs are registered; no combinational input-to-output path.
- redirect held high for multiple RUN cycles gives one TGT_WAIT per RUN cycle in which it is seen. The bubble/target pattern repeats.
- Arithmetic is unsigned D-bit; target is taken verbatim.

Test Plan:
- Reset then start pulse, no other inputs for 5 cycles -> prog_ctr 0,1,2,3,4,5; fetch_valid 1 from first cycle after start; run_cycles = 5.
- At prog_ctr = 7, redirect for one cycle, target = 12'h040 in the following cycle -> prog_ctr holds 7 with fetch_valid 0 for one cycle, then 12'h040 with fetch_valid 1, then 12'h041.
- stall high 3 cycles at prog_ctr = 3, redirect and stall together at prog_ctr = 9 -> PC holds 3 for 3 cycles with fetch_valid 1; at 9 the redirect wins and enters TGT_WAIT.
- halt_req at prog_ctr = 20, then start 4 cycles later -> done = 1 and PC = 20 held; after start: done = 0, prog_ctr = START_PC, run_cycles = 0. Also check halt_req during TGT_WAIT ignores target.
- START_PC = 12'hFFE, no inputs -> FFE, FFF, then HALT with done = 1 and PC held at FFF (no wrap). With CNT_W = 4, run_cycles saturates at 15.
- rst_n asserted asynchronously mid-TGT_WAIT (between edges) -> outputs reset immediately; after release, IDLE ignores redirect/target until start.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch sequencer: start, halt, stall and one-bubble redirect handling plus a saturating run-cycle counter.
// Latency: all outputs registered; a redirect costs one bubble cycle, and the target is loaded at the end of that bubble.
// Backpressure: stall holds prog_ctr with fetch_valid kept high; halt_req and end-of-address-space stop fetch until the next start.
module pc_fetch_ctrl #(
    parameter int unsigned    D        = 12,
    parameter logic [D-1:0]   START_PC = '0,
    parameter int unsigned    CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             stall,
    input  logic             redirect,
    input  logic [D-1:0]     target,
    output logic [D-1:0]     prog_ctr,
    output logic             fetch_valid,
    output logic             done,
    output logic [CNT_W-1:0] run_cycles
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        TGT_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [D-1:0]     PC_MAX  = {D{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state, state_nxt;
    logic [D-1:0]     pc_nxt;
    logic             fv_nxt;
    logic             done_nxt;
    logic [CNT_W-1:0] rc_nxt;

    // State and output registers; reset clears everything even mid-redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prog_ctr    <= '0;
            fetch_valid <= 1'b0;
            done        <= 1'b0;
            run_cycles  <= '0;
        end else begin
            state       <= state_nxt;
            prog_ctr    <= pc_nxt;
            fetch_valid <= fv_nxt;
            done        <= done_nxt;
            run_cycles  <= rc_nxt;
        end
    end

    // Next-state and next-output logic; RUN priority is halt > redirect > stall > increment.
    always_comb begin
        state_nxt = state;
        pc_nxt    = prog_ctr;
        fv_nxt    = fetch_valid;
        done_nxt  = done;
        rc_nxt    = run_cycles;

        // Count every cycle spent fetching or waiting on a target, pinned at the top value.
        if ((state == RUN || state == TGT_WAIT) && run_cycles != CNT_MAX) begin
            rc_nxt = run_cycles + CNT_W'(1);
        end

        case (state)
            IDLE, HALT: begin
                fv_nxt = 1'b0;
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_PC;
                    fv_nxt    = 1'b1;
                    done_nxt  = 1'b0;
                    rc_nxt    = '0;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_nxt = HALT;
                    done_nxt  = 1'b1;
                    fv_nxt    = 1'b0;
                end else if (redirect) begin
                    // Hold the call-site address so the LUT stage still sees it this cycle.
                    state_nxt = TGT_WAIT;
                    fv_nxt    = 1'b0;
                end else if (stall) begin
                    fv_nxt    = 1'b1;
                end else if (prog_ctr == PC_MAX) begin
                    // Running off the end of the address space stops execution rather than wrapping.
                    state_nxt = HALT;
                    done_nxt  = 1'b1;
                    fv_nxt    = 1'b0;
                end else begin
                    pc_nxt    = prog_ctr + D'(1);
                    fv_nxt    = 1'b1;
                end
            end
            TGT_WAIT: begin
                // Decode cannot issue in the bubble, so stall and redirect have no meaning here.
                if (halt_req) begin
                    state_nxt = HALT;
                    done_nxt  = 1'b1;
                    fv_nxt    = 1'b0;
                end else begin
                    state_nxt = RUN;
                    pc_nxt    = target;
                    fv_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                fv_nxt    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: default instance plus a near-top START_PC / narrow-counter instance.
// Each step drives inputs, queues the expected post-edge outputs, then pops and compares after the edge.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start_b;
    logic        halt_req;
    logic        stall;
    logic        redirect;
    logic [11:0] target;

    logic [11:0] prog_ctr;
    logic        fetch_valid;
    logic        done;
    logic [15:0] run_cycles;

    logic [11:0] prog_ctr_b;
    logic        fetch_valid_b;
    logic        done_b;
    logic [3:0]  run_cycles_b;

    int n_vec;
    int n_err;

    typedef struct {
        logic [11:0] pc;
        logic        fv;
        logic        dn;
        logic [15:0] rc;
    } exp_t;

    exp_t sb[$];

    pc_fetch_ctrl #(.D(12), .START_PC(12'h000), .CNT_W(16)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .halt_req    (halt_req),
        .stall       (stall),
        .redirect    (redirect),
        .target      (target),
        .prog_ctr    (prog_ctr),
        .fetch_valid (fetch_valid),
        .done        (done),
        .run_cycles  (run_cycles)
    );

    pc_fetch_ctrl #(.D(12), .START_PC(12'hFFE), .CNT_W(4)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_b),
        .halt_req    (halt_req),
        .stall       (stall),
        .redirect    (redirect),
        .target      (target),
        .prog_ctr    (prog_ctr_b),
        .fetch_valid (fetch_valid_b),
        .done        (done_b),
        .run_cycles  (run_cycles_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pop one scoreboard entry and compare it against the selected instance's outputs.
    task automatic compare(input bit b, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            if (b) begin
                chk({tag, ".pc"}, {4'h0, prog_ctr_b},    {4'h0, e.pc});
                chk({tag, ".fv"}, {15'h0, fetch_valid_b}, {15'h0, e.fv});
                chk({tag, ".dn"}, {15'h0, done_b},        {15'h0, e.dn});
                chk({tag, ".rc"}, {12'h0, run_cycles_b},  e.rc);
            end else begin
                chk({tag, ".pc"}, {4'h0, prog_ctr},    {4'h0, e.pc});
                chk({tag, ".fv"}, {15'h0, fetch_valid}, {15'h0, e.fv});
                chk({tag, ".dn"}, {15'h0, done},        {15'h0, e.dn});
                chk({tag, ".rc"}, run_cycles,           e.rc);
            end
        end
    endtask

    // Check outputs right now (no clock edge), used around asynchronous reset.
    task automatic expect_now(input bit b, input logic [11:0] epc, input logic efv,
                              input logic edn, input logic [15:0] erc, input string tag);
        sb.push_back('{pc: epc, fv: efv, dn: edn, rc: erc});
        compare(b, tag);
    endtask

    // One clock: drive inputs, queue the expected result, wait for the edge, then compare.
    task automatic step(input bit b, input logic s, input logic h, input logic st,
                        input logic r, input logic [11:0] t,
                        input logic [11:0] epc, input logic efv, input logic edn,
                        input logic [15:0] erc, input string tag);
        start    = b ? 1'b0 : s;
        start_b  = b ? s : 1'b0;
        halt_req = h;
        stall    = st;
        redirect = r;
        target   = t;
        sb.push_back('{pc: epc, fv: efv, dn: edn, rc: erc});
        @(posedge clk);
        #1;
        compare(b, tag);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        start_b  = 1'b0;
        halt_req = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        target   = 12'h000;

        #3;
        expect_now(1'b0, 12'h000, 1'b0, 1'b0, 16'd0, "rst_a");
        expect_now(1'b1, 12'h000, 1'b0, 1'b0, 16'd0, "rst_b");
        #9;
        rst_n = 1'b1;

        // Start and free-run: PC 0..7, counter tracks RUN cycles.
        step(0, 1, 0, 0, 0, 12'h000, 12'h000, 1, 0, 16'd0, "start");
        for (int i = 1; i <= 7; i++)
            step(0, 0, 0, 0, 0, 12'h000, 12'(i), 1, 0, 16'(i), $sformatf("inc%0d", i));

        // Redirect at 7: one bubble holding 7, then target 040, then 041.
        step(0, 0, 0, 0, 1, 12'h000, 12'h007, 0, 0, 16'd8,  "redir_bubble");
        step(0, 0, 0, 0, 0, 12'h040, 12'h040, 1, 0, 16'd9,  "redir_tgt");
        step(0, 0, 0, 0, 0, 12'h000, 12'h041, 1, 0, 16'd10, "post_tgt");
        step(0, 0, 0, 0, 1, 12'h000, 12'h041, 0, 0, 16'd11, "redir2_bubble");
        step(0, 0, 0, 0, 0, 12'h014, 12'h014, 1, 0, 16'd12, "redir2_tgt");

        // Halt at PC 20; HALT ignores everything but start.
        step(0, 0, 1, 0, 0, 12'h000, 12'h014, 0, 1, 16'd13, "halt");
        step(0, 0, 0, 0, 0, 12'h000, 12'h014, 0, 1, 16'd13, "halt_hold1");
        step(0, 0, 1, 1, 1, 12'h0AA, 12'h014, 0, 1, 16'd13, "halt_hold2");
        step(0, 0, 0, 0, 0, 12'h000, 12'h014, 0, 1, 16'd13, "halt_hold3");
        step(0, 1, 0, 0, 0, 12'h000, 12'h000, 1, 0, 16'd0,  "restart");

        // Stall for 3 cycles at PC 3, then redirect+stall at 9.
        step(0, 0, 0, 0, 0, 12'h000, 12'h001, 1, 0, 16'd1, "b_inc1");
        step(0, 0, 0, 0, 0, 12'h000, 12'h002, 1, 0, 16'd2, "b_inc2");
        step(0, 0, 0, 0, 0, 12'h000, 12'h003, 1, 0, 16'd3, "b_inc3");
        for (int i = 1; i <= 3; i++)
            step(0, 0, 0, 1, 0, 12'h000, 12'h003, 1, 0, 16'(3 + i), $sformatf("stall%0d", i));
        for (int i = 4; i <= 9; i++)
            step(0, 0, 0, 0, 0, 12'h000, 12'(i), 1, 0, 16'(i + 3), $sformatf("b_inc%0d", i));
        step(0, 0, 0, 1, 1, 12'h000, 12'h009, 0, 0, 16'd13, "redir_over_stall");
        // Halt during the bubble discards the target.
        step(0, 0, 1, 1, 0, 12'h123, 12'h009, 0, 1, 16'd14, "halt_in_wait");
        step(0, 0, 0, 0, 0, 12'h000, 12'h009, 0, 1, 16'd14, "halt_in_wait_hold");

        // Start beats a simultaneous halt; redirect held high gives repeated bubbles.
        step(0, 1, 1, 0, 0, 12'h000, 12'h000, 1, 0, 16'd0, "start_over_halt");
        step(0, 0, 0, 0, 1, 12'h000, 12'h000, 0, 0, 16'd1, "hold_redir1");
        step(0, 0, 0, 1, 1, 12'h100, 12'h100, 1, 0, 16'd2, "wait_ignores_stall");
        step(0, 0, 0, 0, 1, 12'h200, 12'h100, 0, 0, 16'd3, "hold_redir2");
        step(0, 0, 0, 0, 0, 12'h200, 12'h200, 1, 0, 16'd4, "hold_redir2_tgt");
        step(0, 0, 0, 1, 0, 12'h000, 12'h200, 1, 0, 16'd5, "stall_single");
        step(0, 0, 0, 0, 1, 12'h000, 12'h200, 0, 0, 16'd6, "redir_pre_reset");

        // Asynchronous reset between edges while in the bubble.
        #2;
        rst_n = 1'b0;
        #1;
        expect_now(0, 12'h000, 1'b0, 1'b0, 16'd0, "async_rst");
        #2;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1, 12'h055, 12'h000, 0, 0, 16'd0, "idle_ignore_redir");
        step(0, 0, 1, 1, 0, 12'h055, 12'h000, 0, 0, 16'd0, "idle_ignore_tgt");
        step(0, 1, 0, 0, 0, 12'h000, 12'h000, 1, 0, 16'd0, "start_after_rst");
        step(0, 0, 0, 0, 0, 12'h000, 12'h001, 1, 0, 16'd1, "inc_after_rst");

        // Second instance: top of address space halts without wrapping.
        step(1, 1, 0, 0, 0, 12'h000, 12'hFFE, 1, 0, 16'd0, "top_start");
        step(1, 0, 0, 0, 0, 12'h000, 12'hFFF, 1, 0, 16'd1, "top_fff");
        step(1, 0, 0, 0, 0, 12'h000, 12'hFFF, 0, 1, 16'd2, "top_nowrap");
        step(1, 0, 0, 0, 0, 12'h000, 12'hFFF, 0, 1, 16'd2, "top_hold");

        // 4-bit counter saturates at 15 while stalled in RUN.
        step(1, 1, 0, 0, 0, 12'h000, 12'hFFE, 1, 0, 16'd0, "sat_start");
        for (int i = 1; i <= 17; i++)
            step(1, 0, 0, 1, 0, 12'h000, 12'hFFE, 1, 0, 16'((i > 15) ? 15 : i),
                 $sformatf("sat%0d", i));
        step(1, 0, 0, 0, 0, 12'h000, 12'hFFF, 1, 0, 16'd15, "sat_fff");
        step(1, 0, 0, 0, 0, 12'h000, 12'hFFF, 0, 1, 16'd15, "sat_halt");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
